// File: rtl/vec_add_arbiter.sv
// Round-robin sharing of one registered vec3 two's-complement adder among NUM_REQ requesters.
// Optional macro VEC_ADD_ARB_STATS_EN adds the per-requester grant_count output.
module vec_add_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0] x,
  input  logic [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0] y,
  input  logic [NUM_REQ-1:0]                      in_empty,
  output logic [NUM_REQ-1:0]                      in_rd_en,
  output logic [2:0][DATA_WIDTH-1:0]              out,
  input  logic [NUM_REQ-1:0]                      out_full,
  output logic [NUM_REQ-1:0]                      out_wr_en,
  output logic                                    busy
`ifdef VEC_ADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]                grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_ARB,
    S_WRITE
  } state_t;

  state_t                     state_q, state_d;
  logic [2:0][DATA_WIDTH-1:0] out_q, out_d;
  logic [IDX_W-1:0]           grant_q, grant_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;

  // A requester whose result FIFO is full is skipped so it cannot stall the rest.
  assign elig = ~in_empty & ~out_full;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    in_rd_en  = '0;
    out_wr_en = '0;
    busy      = 1'b0;
    unique case (state_q)
      S_ARB: begin
        if (found) begin
          in_rd_en[winner] = 1'b1;
          for (int k = 0; k < 3; k++) begin
            out_d[k] = x[winner][k] + y[winner][k];
          end
          grant_d  = winner;
          rr_ptr_d = winner;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        busy = 1'b1;
        if (!out_full[grant_q]) begin
          out_wr_en[grant_q] = 1'b1;
          state_d            = S_ARB;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_ARB;
      out_q    <= '0;
      grant_q  <= '0;
      rr_ptr_q <= RR_RESET;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out = out_q;

`ifdef VEC_ADD_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (in_rd_en[i]) grant_count_q[i] <= grant_count_q[i] + 16'd1;
      end
    end
  end

  assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_vec_add_arbiter.sv
// Directed self-checking bench for vec_add_arbiter with two requesters and modelled FWFT FIFOs.
module tb_vec_add_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;

  typedef logic [2:0][DW-1:0] vec_t;
  typedef struct {
    vec_t a;
    vec_t b;
  } op_t;

  logic                          clock = 1'b0;
  logic                          reset;
  logic [NR-1:0][2:0][DW-1:0]    x, y;
  logic [NR-1:0]                 in_empty;
  logic [NR-1:0]                 in_rd_en;
  logic [2:0][DW-1:0]            out;
  logic [NR-1:0]                 out_full;
  logic [NR-1:0]                 out_wr_en;
  logic                          busy;
`ifdef VEC_ADD_ARB_STATS_EN
  logic [NR-1:0][15:0]           grant_count;
`endif

  vec_add_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out       (out),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .busy      (busy)
`ifdef VEC_ADD_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clock = ~clock;

  op_t  opq  [NR][$];
  vec_t expq [NR][$];
  vec_t resq [NR][$];
  int   grant_log[$];

  logic [NR-1:0] last_rd, last_wr;
  vec_t          last_out;
  logic          last_busy;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                              input logic [DW-1:0] c2);
    vec_t v;
    v[0] = c0;
    v[1] = c1;
    v[2] = c2;
    return v;
  endfunction

  task automatic update_inputs();
    for (int i = 0; i < NR; i++) begin
      in_empty[i] = (opq[i].size() == 0);
      x[i] = (opq[i].size() != 0) ? opq[i][0].a : '0;
      y[i] = (opq[i].size() != 0) ? opq[i][0].b : '0;
    end
  endtask

  task automatic push_op(input int r, input vec_t a, input vec_t b, input vec_t e);
    op_t op;
    op.a = a;
    op.b = b;
    opq[r].push_back(op);
    expq[r].push_back(e);
    update_inputs();
  endtask

  // One clock cycle: sample outputs mid-cycle, then apply FIFO pops just after the edge.
  task automatic step();
    @(negedge clock);
    last_rd   = in_rd_en;
    last_wr   = out_wr_en;
    last_out  = out;
    last_busy = busy;
    check("onehot_rd", 128'($onehot0(last_rd)), 128'd1);
    check("onehot_wr", 128'($onehot0(last_wr)), 128'd1);
    check("rd_wr_excl", 128'((|last_rd) && (|last_wr)), 128'd0);
    for (int i = 0; i < NR; i++) begin
      if (last_rd[i]) grant_log.push_back(i);
      if (last_wr[i]) resq[i].push_back(last_out);
    end
    @(posedge clock);
    #1;
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        if (last_rd[i] && opq[i].size() != 0) void'(opq[i].pop_front());
      end
    end
    update_inputs();
  endtask

  task automatic compare_results(input string tag);
    for (int i = 0; i < NR; i++) begin
      check({tag, "_count"}, 128'(resq[i].size()), 128'(expq[i].size()));
      for (int j = 0; j < resq[i].size() && j < expq[i].size(); j++) begin
        check({tag, "_data"}, 128'(resq[i][j]), 128'(expq[i][j]));
      end
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NR; i++) begin
      resq[i].delete();
      expq[i].delete();
    end
    grant_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    out_full = '0;
    update_inputs();
    #2;
    check("rst_rd", 128'(in_rd_en), 128'd0);
    check("rst_wr", 128'(out_wr_en), 128'd0);
    check("rst_out", 128'(out), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
`ifdef VEC_ADD_ARB_STATS_EN
    check("rst_gcount", 128'(grant_count), 128'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle with every operand FIFO empty.
    repeat (10) begin
      step();
      check("idle", 128'({last_rd, last_wr, last_busy, last_out}), 128'd0);
    end

    // Single transaction on req0: pop in cycle N, push in N+1.
    push_op(0, mk(1, 2, 3), mk(10, 20, 30), mk(11, 22, 33));
    step();
    check("single_rd", 128'(last_rd), 128'(2'b01));
    check("single_wr_n", 128'(last_wr), 128'd0);
    check("single_busy_n", 128'(last_busy), 128'd0);
    step();
    check("single_wr", 128'(last_wr), 128'(2'b01));
    check("single_out", 128'(last_out), 128'(mk(11, 22, 33)));
    check("single_busy", 128'(last_busy), 128'd1);
    step();
    check("single_idle", 128'({last_rd, last_wr}), 128'd0);
    compare_results("single");
    clear_logs();

    // Alternation: four entries each, never full.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < NR; i++) begin
        push_op(i, mk(j, i, 100), mk(10 * i, j + 1, -1), mk(j + 10 * i, i + j + 1, 99));
      end
    end
    repeat (16) step();
    check("alt_grants", 128'(grant_log.size()), 128'd8);
    for (int k = 0; k < grant_log.size(); k++) begin
      check("alt_order", 128'(grant_log[k]), 128'(k % 2));
    end
    compare_results("alt");
`ifdef VEC_ADD_ARB_STATS_EN
    check("alt_gcount0", 128'(grant_count[0]), 128'd4);
    check("alt_gcount1", 128'(grant_count[1]), 128'd4);
`endif
    clear_logs();

    // req1 result FIFO full: only req0 served until it drains.
    out_full = 2'b10;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NR; i++) begin
        push_op(i, mk(i, j, 7), mk(1, 1, 1), mk(i + 1, j + 1, 8));
      end
    end
    repeat (4) step();
    check("full_grants", 128'(grant_log.size()), 128'd2);
    for (int k = 0; k < grant_log.size(); k++) begin
      check("full_only0", 128'(grant_log[k]), 128'd0);
    end
    check("full_no_req1", 128'(resq[1].size()), 128'd0);
    out_full = 2'b00;
    step();
    check("release_rd", 128'(last_rd), 128'(2'b10));
    step();
    check("release_wr", 128'(last_wr), 128'(2'b10));
    repeat (2) step();
    compare_results("full");
    clear_logs();

    // Result FIFO goes full during S_WRITE: hold, keep out stable, grant nobody else.
    push_op(0, mk(5, 6, 7), mk(1, 1, 1), mk(6, 7, 8));
    step();
    check("hold_rd", 128'(last_rd), 128'(2'b01));
    out_full = 2'b01;
    push_op(1, mk(2, 2, 2), mk(3, 3, 3), mk(5, 5, 5));
    repeat (2) begin
      step();
      check("hold_wr", 128'({last_rd, last_wr}), 128'd0);
      check("hold_busy", 128'(last_busy), 128'd1);
      check("hold_out", 128'(last_out), 128'(mk(6, 7, 8)));
    end
    out_full = 2'b00;
    step();
    check("hold_release_wr", 128'(last_wr), 128'(2'b01));
    step();
    check("hold_next_rd", 128'(last_rd), 128'(2'b10));
    step();
    compare_results("hold");
    clear_logs();

    // Wrap-around arithmetic.
    push_op(0, mk(32'h7FFF_FFFF, 32'h8000_0000, -5), mk(1, -1, 5),
            mk(32'h8000_0000, 32'h7FFF_FFFF, 0));
    step();
    step();
    check("ovf_out", 128'(last_out), 128'(mk(32'h8000_0000, 32'h7FFF_FFFF, 0)));
    check("ovf_wr", 128'(last_wr), 128'(2'b01));
    clear_logs();

    // Reset while in S_WRITE: result dropped, pointer back to reset value.
    push_op(0, mk(9, 9, 9), mk(1, 1, 1), mk(10, 10, 10));
    step();
    check("rstmid_rd", 128'(last_rd), 128'(2'b01));
    reset = 1'b1;
    expq[0].delete();
    step();
    check("rstmid_wr", 128'(last_wr), 128'd0);
    check("rstmid_busy", 128'(last_busy), 128'd0);
    check("rstmid_out", 128'(last_out), 128'd0);
`ifdef VEC_ADD_ARB_STATS_EN
    check("rstmid_gcount", 128'(grant_count), 128'd0);
`endif
    reset = 1'b0;
    push_op(0, mk(1, 0, 0), mk(2, 0, 0), mk(3, 0, 0));
    push_op(1, mk(0, 4, 0), mk(0, 5, 0), mk(0, 9, 0));
    step();
    check("rstmid_next_rd", 128'(last_rd), 128'(2'b01));
    repeat (3) step();
    compare_results("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_add_arbiter.md
Name: vec_add_arbiter

Overview:
- Shares one registered vec3 signed adder among NUM_REQ requesters in the ray-tracer fixed-point math pipeline.
- Each requester has an operand FIFO (x, y) on the input side and a result FIFO on the output side.
- Arbitration is round-robin. A requester is granted only when its operand FIFO is non-empty and its result FIFO is not full, so one stalled consumer never blocks the others.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- DATA_WIDTH, 32, width of each signed vector component.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- x  input  [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0]  per-requester operand x, FWFT data from operand FIFO
- y  input  [NUM_REQ-1:0][2:0][DATA_WIDTH-1:0]  per-requester operand y, FWFT data from operand FIFO
- in_empty  input  NUM_REQ  per-requester operand FIFO empty
- in_rd_en  output  NUM_REQ  per-requester operand pop, one-hot or zero
- out  output  [2:0][DATA_WIDTH-1:0]  shared result bus, fans out to every result FIFO din
- out_full  input  NUM_REQ  per-requester result FIFO full
- out_wr_en  output  NUM_REQ  per-requester result push, one-hot or zero
- busy  output  1  high while in S_WRITE

Behaviour:
- Reset (asynchronous):
  - state=S_ARB, out=0, grant_id=0, rr_ptr=NUM_REQ-1.
  - in_rd_en, out_wr_en and busy are combinational and read 0 in S_ARB with no eligible requester.
- Eligibility: elig[i] = !in_empty[i] && !out_full[i].
- Round-robin selection:
  - Search starts at (rr_ptr+1) mod NUM_REQ and wraps; the first eligible index wins.
  - rr_ptr <= winner on grant.
- S_ARB:
  - If any elig, assert in_rd_en[winner] combinationally in the same cycle.
  - Register out[k] <= x[winner][k] + y[winner][k] for k=0..2.
  - grant_id <= winner; go to S_WRITE.
  - If no elig, hold state; out is unchanged.
- S_WRITE:
  - busy=1.
  - If !out_full[grant_id]: out_wr_en[grant_id]=1, go to S_ARB.
  - Otherwise hold and keep out stable; no other requester is granted meanwhile.
- Latency and throughput:
  - Pop in cycle N; push in cycle N+1 (minimum).
  - Peak throughput is one result per 2 cycles.
- Arithmetic: DATA_WIDTH-bit two's-complement add, wrap on overflow, no saturation, no flags.
- Invariants:
  - At most one in_rd_en bit and at most one out_wr_en bit high per cycle.
  - in_rd_en and out_wr_en are never both high in the same cycle.
- Reset mid-operation (S_WRITE):
  - The pending result is discarded; no out_wr_en is issued.
  - rr_ptr returns to its reset value.

Optional Feature:
- Macro VEC_ADD_ARB_STATS_EN.
- When defined:
  - Adds output grant_count [NUM_REQ-1:0][15:0].
  - grant_count[i] increments on every in_rd_en[i] and wraps at 16 bits.
  - Reset clears it to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset → in_rd_en=0, out_wr_en=0, out=0, busy=0; with all in_empty=1 the outputs stay 0 for 10 cycles.
- Only req0 non-empty, x=(1,2,3), y=(10,20,30) → in_rd_en=01 in cycle N; out=(11,22,33) with out_wr_en=01 in cycle N+1.
- Both requesters hold 4 entries each, outputs never full → grants alternate 0,1,0,1,...; 8 results in 16 cycles; each FIFO receives its own sums in order.
- out_full[1]=1, both inputs non-empty → only req0 is served. Drop out_full[1] → req1 is granted at the next S_ARB.
- x[0]=(0x7FFFFFFF,0x80000000,-5), y[0]=(1,-1,5) → out=(0x80000000,0x7FFFFFFF,0).
- Assert reset during S_WRITE → no out_wr_en; state=S_ARB; next grant goes to req0. With VEC_ADD_ARB_STATS_EN: grant_count=0 after reset, and equals the pop count per requester after the alternation test.
